// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters; one start/done transaction per grant.
// Optional WAIT-state abort is enabled by defining ALU_REQ_ARBITER_TIMEOUT_EN.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_a,
    input  logic [DATA_W*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [2*DATA_W-1:0]         resp_data,
    output logic                        busy,
    output logic                        alu_start,
    output logic [1:0]                  alu_op_code,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    input  logic                        alu_done,
    input  logic [2*DATA_W-1:0]         alu_result,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {StIdle, StGrant, StStart, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] res_q, res_d;

    logic                found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic [1:0]          op_sel;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;

`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                op_sel = req_op[2*i +: 2];
                a_sel  = req_a[DATA_W*i +: DATA_W];
                b_sel  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    idx_d   = win_idx;
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    state_d = StGrant;
                end
            end
            StGrant: state_d = StStart;
            StStart: begin
`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
                cnt_d = '0;
                to_d  = 1'b0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = StResp;
                end
`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
                // A done in the timeout cycle takes priority over the abort.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    res_d   = '1;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            StResp: begin
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_err = (state_q == StResp) && to_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy        = (state_q != StIdle);
    assign alu_start   = (state_q == StStart);
    assign gnt         = (state_q == StGrant) ? (NUM_REQ'(1) << idx_q) : '0;
    assign resp_valid  = (state_q == StResp) ? (NUM_REQ'(1) << idx_q) : '0;
    assign resp_data   = res_q;
    assign alu_op_code = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: scoreboard of expected transactions, bench-side ALU model.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  gnt;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        busy;
    logic        alu_start;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        timeout_err;

    alu_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .alu_start   (alu_start),
        .alu_op_code (alu_op_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
    } txn_t;

    txn_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;

    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [7:0] r8;
        case (op)
            2'b00:   begin r8 = a + b; return {8'h00, r8}; end
            2'b01:   begin r8 = a - b; return {8'h00, r8}; end
            2'b10:   return 16'(a) * 16'(b);
            default: return {a % b, a / b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive requester idx's operands, raise its request, and queue the expected result.
    task automatic push(input int idx, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        txn_t e;
        req_op[2*idx +: 2] = op;
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
        req[idx]           = 1'b1;
        e.idx = idx; e.op = op; e.a = a; e.b = b; e.res = alu_model(op, a, b);
        sb.push_back(e);
    endtask

    // Service the transaction at the scoreboard head; done arrives `delay` cycles after start.
    task automatic serve(input int delay, input logic [3:0] drop_mask, input bit spur,
                         output int n);
        txn_t e;
        n = 0;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb[0];
        while (gnt === 4'b0 && n < 32) begin
            tick();
            n++;
        end
        chk("gnt", gnt, 4'b1 << e.idx);
        chk("busy_grant", busy, 1);
        chk("start_in_grant", alu_start, 0);
        req = req & ~drop_mask;
        tick();
        chk("alu_start", alu_start, 1);
        chk("gnt_pulse", gnt, 0);
        chk("alu_op_code", alu_op_code, e.op);
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        if (spur) begin
            alu_done   = 1'b1;
            alu_result = 16'hDEAD;
        end
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        chk("start_pulse", alu_start, 0);
        chk("no_early_resp", resp_valid, 0);
        chk("busy_wait", busy, 1);
        repeat (delay - 1) tick();
        alu_done   = 1'b1;
        alu_result = e.res;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        chk("resp_valid", resp_valid, 4'b1 << e.idx);
        chk("resp_data", resp_data, e.res);
        chk("timeout_err_clear", timeout_err, 0);
        chk("alu_a_held", alu_a, e.a);
        void'(sb.pop_front());
        tick();
        chk("resp_single", resp_valid, 0);
        chk("busy_idle", busy, 0);
        chk("resp_data_held", resp_data, e.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_ops", {alu_op_code, alu_a, alu_b}, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single add: gnt one cycle after the sampling edge.
        push(0, 2'b00, 8'd5, 8'd3);
        serve(2, 4'b0001, 1'b0, lat);
        chk("add_latency", lat, 1);

        // Simultaneous requests from reset: 1 then 2.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(1, 2'b01, 8'd9, 8'd4);
        push(2, 2'b00, 8'd250, 8'd10);
        serve(3, 4'b0010, 1'b0, lat);
        serve(1, 4'b0100, 1'b0, lat);
        chk("sim_second_latency", lat, 1);

        // Fairness: all four held, mul ops.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(0, 2'b10, 8'd3, 8'd7);
        push(1, 2'b10, 8'd200, 8'd2);
        push(2, 2'b10, 8'd255, 8'd255);
        push(3, 2'b10, 8'd16, 8'd16);
        sb.push_back(sb[0]);
        for (int t = 0; t < 5; t++) begin
            serve(2, (t == 4) ? 4'b1111 : 4'b0000, 1'b0, lat);
            chk("fair_one_idle", lat, 1);
        end

        // Spurious done in IDLE and START; ptr is now 1.
        alu_done   = 1'b1;
        alu_result = 16'hBEEF;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        chk("spur_idle_no_resp", resp_valid, 0);
        chk("spur_idle_no_busy", busy, 0);
        push(1, 2'b10, 8'd20, 8'd10);
        chk("mul_model", sb[0].res, 16'h00C8);
        serve(2, 4'b0010, 1'b1, lat);

        // Reset three cycles into WAIT aborts without a response.
        req_op[7:6] = 2'b11;
        req_a[31:24] = 8'd50;
        req_b[31:24] = 8'd5;
        req[3] = 1'b1;
        tick();
        chk("abort_gnt", gnt, 4'b1000);
        req[3] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("abort_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_gnt_zero", gnt, 0);
        chk("abort_resp_zero", resp_valid, 0);
        chk("abort_busy_zero", busy, 0);
        chk("abort_start_zero", alu_start, 0);
        tick();
        reset = 1'b0;
        push(2, 2'b01, 8'd7, 8'd9);
        serve(4, 4'b0100, 1'b0, lat);
        chk("post_reset_latency", lat, 1);

        // Pointer now 3: requesters 0 and 3 both asking resolves to 3 first.
        push(3, 2'b11, 8'd100, 8'd7);
        push(0, 2'b00, 8'd1, 8'd1);
        serve(1, 4'b1000, 1'b0, lat);
        serve(2, 4'b0001, 1'b0, lat);

`ifdef ALU_REQ_ARBITER_TIMEOUT_EN
        // ptr is 1; div with no done aborts after 64 WAIT cycles.
        begin
            txn_t e;
            e.idx = 1; e.op = 2'b11; e.a = 8'd77; e.b = 8'd3; e.res = 16'hFFFF;
            req_op[3:2] = e.op;
            req_a[15:8] = e.a;
            req_b[15:8] = e.b;
            req[1]      = 1'b1;
            sb.push_back(e);
            tick();
            chk("to_gnt", gnt, 4'b0010);
            req[1] = 1'b0;
            tick();
            tick();
            repeat (63) tick();
            chk("to_not_early", resp_valid, 0);
            chk("to_err_not_early", timeout_err, 0);
            tick();
            chk("to_resp_valid", resp_valid, 4'b1 << sb[0].idx);
            chk("to_err", timeout_err, 1);
            chk("to_resp_data", resp_data, sb[0].res);
            void'(sb.pop_front());
            tick();
            chk("to_err_pulse", timeout_err, 0);
            chk("to_busy_idle", busy, 0);
        end
`endif

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
